// File: rtl/loader_pkg.sv
// Shared types and defaults for the ROM download write-queue.
package loader_pkg;

  localparam int LOADER_DEPTH  = 8;
  localparam int LOADER_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic [LOADER_ADDR_W-1:0] addr;
    logic [7:0]               data;
  } loader_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Single-clock FIFO of loader entries; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int  DEPTH   = LOADER_DEPTH,
  parameter type entry_t = loader_entry_t
) (
  input  logic   clk_sys,
  input  logic   reset,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader_queue.sv
// Write-queue from data_io byte strobes to the SDRAM loader port, one byte per
// mem_sync slot. Define LOADER_CHECKSUM_EN to add a 16-bit sum of committed bytes.
module rom_loader_queue
  import loader_pkg::*;
#(
  parameter int DEPTH  = LOADER_DEPTH,
  parameter int ADDR_W = LOADER_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              mem_sync,
  output logic              loader_active,
  output logic              loader_we,
  output logic [ADDR_W-1:0] loader_addr,
  output logic [7:0]        loader_data,
  output logic              overflow,
  output logic              done,
  output loader_state_t     dbg_state
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  // Handshake: ioctl_wr is a one-cycle strobe with no back-pressure (a byte
  // that finds the queue full is dropped and flagged); loader_we/addr/data are
  // launched right after a mem_sync and held until the next mem_sync samples them.
  loader_state_t state;
  logic          dl_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        head;
  entry_t        in_entry;

  assign dl_rise       = ioctl_download && !dl_q;
  assign dl_fall       = !ioctl_download && dl_q;
  assign push          = ioctl_wr && (state == LOAD);
  assign pop           = mem_sync && !fifo_empty;
  assign in_entry      = '{addr: ioctl_addr, data: ioctl_dout};
  assign loader_active = (state != IDLE);
  assign dbg_state     = state;

  loader_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (in_entry),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (head)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      dl_q        <= 1'b0;
      loader_we   <= 1'b0;
      loader_addr <= '0;
      loader_data <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      dl_q <= ioctl_download;
      done <= 1'b0;

      if (mem_sync) begin
        if (!fifo_empty) begin
          loader_we   <= 1'b1;
          loader_addr <= head.addr;
          loader_data <= head.data;
        end else begin
          loader_we   <= 1'b0;
        end
      end

      if (push && fifo_full && !pop) overflow <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (pop) checksum <= checksum + 16'(head.data);
`endif

      // Entering LOAD starts a fresh session: the clears below override the
      // accumulate above, while queued bytes from a previous session stay.
      case (state)
        IDLE: begin
          if (dl_rise) begin
            state    <= LOAD;
            overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        LOAD: begin
          if (dl_fall) state <= DRAIN;
        end
        DRAIN: begin
          if (dl_rise) begin
            state    <= LOAD;
            overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
          end else if (mem_sync && fifo_empty) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader_queue.sv
// Directed bench for rom_loader_queue: a vector table for a basic download plus
// hand-written sequences for overflow, full push/pop, drain, reset and latency.
module tb_rom_loader_queue;
  import loader_pkg::*;

  localparam int ADDR_W = 25;
  localparam int DEPTH  = 8;
  localparam int NVEC   = 18;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              mem_sync;
  logic              loader_active;
  logic              loader_we;
  logic [ADDR_W-1:0] loader_addr;
  logic [7:0]        loader_data;
  logic              overflow;
  logic              done;
  loader_state_t     dbg_state;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+7:0] exp_q[$];

  typedef struct packed {
    logic              dl;
    logic              wr;
    logic              ms;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_data;
    logic              e_act;
    logic              e_done;
  } vec_t;

  vec_t tbl [NVEC];

  rom_loader_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .overflow       (overflow),
    .done           (done),
    .dbg_state      (dbg_state)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  // Clock and reset
  always #5 clk_sys = ~clk_sys;

  function automatic vec_t mk(input logic dl, input logic wr, input logic ms,
                              input logic [ADDR_W-1:0] a, input logic [7:0] d,
                              input logic we, input logic [ADDR_W-1:0] ea,
                              input logic [7:0] ed, input logic act, input logic dn);
    vec_t v;
    v.dl = dl; v.wr = wr; v.ms = ms; v.addr = a; v.data = d;
    v.e_we = we; v.e_addr = ea; v.e_data = ed; v.e_act = act; v.e_done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs for one cycle, return 1 time unit after the edge.
  task automatic drive(input logic dl, input logic wr, input logic ms,
                       input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_download = dl;
    ioctl_wr       = wr;
    mem_sync       = ms;
    ioctl_addr     = a;
    ioctl_dout     = d;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic keep);
    drive(1'b1, 1'b1, 1'b0, a, d);
    if (keep) exp_q.push_back({a, d});
  endtask

  // One slot: mem_sync then three idle cycles; the head of exp_q must commit.
  task automatic slot(input string name, input logic dl);
    logic [ADDR_W+7:0] e;
    drive(dl, 1'b0, 1'b1, '0, '0);
    if (exp_q.size() == 0) begin
      chk({name, " unexpected slot"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, " we"}, 32'(loader_we), 32'd1);
      chk({name, " addr"}, 32'(loader_addr), 32'(e[ADDR_W+7:8]));
      chk({name, " data"}, 32'(loader_data), 32'(e[7:0]));
      repeat (3) drive(dl, 1'b0, 1'b0, '0, '0);
      chk({name, " hold we"}, 32'(loader_we), 32'd1);
      chk({name, " hold data"}, 32'(loader_data), 32'(e[7:0]));
    end
  endtask

  task automatic end_slot(input string name);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    chk({name, " we low"}, 32'(loader_we), 32'd0);
    chk({name, " active low"}, 32'(loader_active), 32'd0);
    chk({name, " done"}, 32'(done), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, '0, '0, 0, '0, '0, 1, 0);
    tbl[1]  = mk(1, 1, 0, 25'h0A000, 8'h11, 0, '0, '0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 25'h0A001, 8'h22, 0, '0, '0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 25'h0A002, 8'h33, 0, '0, '0, 1, 0);
    tbl[4]  = mk(0, 0, 1, '0, '0, 1, 25'h0A000, 8'h11, 1, 0);
    tbl[5]  = mk(0, 0, 0, '0, '0, 1, 25'h0A000, 8'h11, 1, 0);
    tbl[6]  = mk(0, 0, 0, '0, '0, 1, 25'h0A000, 8'h11, 1, 0);
    tbl[7]  = mk(0, 0, 0, '0, '0, 1, 25'h0A000, 8'h11, 1, 0);
    tbl[8]  = mk(0, 0, 1, '0, '0, 1, 25'h0A001, 8'h22, 1, 0);
    tbl[9]  = mk(0, 0, 0, '0, '0, 1, 25'h0A001, 8'h22, 1, 0);
    tbl[10] = mk(0, 0, 0, '0, '0, 1, 25'h0A001, 8'h22, 1, 0);
    tbl[11] = mk(0, 0, 0, '0, '0, 1, 25'h0A001, 8'h22, 1, 0);
    tbl[12] = mk(0, 0, 1, '0, '0, 1, 25'h0A002, 8'h33, 1, 0);
    tbl[13] = mk(0, 0, 0, '0, '0, 1, 25'h0A002, 8'h33, 1, 0);
    tbl[14] = mk(0, 0, 0, '0, '0, 1, 25'h0A002, 8'h33, 1, 0);
    tbl[15] = mk(0, 0, 0, '0, '0, 1, 25'h0A002, 8'h33, 1, 0);
    tbl[16] = mk(0, 0, 1, '0, '0, 0, 25'h0A002, 8'h33, 0, 1);
    tbl[17] = mk(0, 0, 0, '0, '0, 0, 25'h0A002, 8'h33, 0, 0);

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    chk("reset we", 32'(loader_we), 32'd0);
    chk("reset addr", 32'(loader_addr), 32'd0);
    chk("reset data", 32'(loader_data), 32'd0);
    chk("reset active", 32'(loader_active), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Three-byte download, mem_sync every 4 cycles
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].dl, tbl[i].wr, tbl[i].ms, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d we", i), 32'(loader_we), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d addr", i), 32'(loader_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d data", i), 32'(loader_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d active", i), 32'(loader_active), 32'(tbl[i].e_act));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'd0);
    end
`ifdef LOADER_CHECKSUM_EN
    chk("basic checksum", 32'(checksum), 32'h0066);
`endif

    // Ten back-to-back strobes with no mem_sync: last two dropped
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) strobe(25'h10000 + 25'(i), 8'hA0 + 8'(i), i < DEPTH);
    chk("ovf sticky set", 32'(overflow), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) slot("ovf drain", 1'b0);
    end_slot("ovf end");
    chk("ovf held in idle", 32'(overflow), 32'd1);

    // Full FIFO, strobe coincident with mem_sync: accepted
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("ovf cleared on rise", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) strobe(25'h20000 + 25'(i), 8'h50 + 8'(i), 1'b1);
    drive(1'b1, 1'b1, 1'b1, 25'h20008, 8'h58);
    exp_q.push_back({25'h20008, 8'h58});
    chk("full pp we", 32'(loader_we), 32'd1);
    chk("full pp data", 32'(loader_data), 32'h50);
    void'(exp_q.pop_front());
    chk("full pp overflow", 32'(overflow), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) slot("full drain", 1'b0);
    end_slot("full end");
    chk("full no drop", 32'(overflow), 32'd0);

    // Fall with 5 queued; strobe during DRAIN ignored
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) strobe(25'h30000 + 25'(i), 8'hC0 + 8'(i), 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 25'h3FFFF, 8'hEE);
    for (int i = 0; i < 5; i++) begin
      slot("drain", 1'b0);
      chk("drain active", 32'(loader_active), 32'd1);
    end
    end_slot("drain end");

    // Reset mid-LOAD with 4 queued
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) strobe(25'h40000 + 25'(i), 8'h70 + 8'(i), 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    chk("midrst we", 32'(loader_we), 32'd0);
    chk("midrst addr", 32'(loader_addr), 32'd0);
    chk("midrst data", 32'(loader_data), 32'd0);
    chk("midrst active", 32'(loader_active), 32'd0);
    chk("midrst state", 32'(dbg_state), 32'(IDLE));
`ifdef LOADER_CHECKSUM_EN
    chk("midrst checksum", 32'(checksum), 32'd0);
`endif
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    chk("postrst sync we", 32'(loader_we), 32'd0);
    chk("postrst active", 32'(loader_active), 32'd0);

    // Strobe coincident with mem_sync into an empty FIFO waits a slot
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b1, 25'h50000, 8'h99);
    chk("coinc not committed", 32'(loader_we), 32'd0);
    chk("coinc data held", 32'(loader_data), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    exp_q.push_back({25'h50000, 8'h99});
    slot("coinc next slot", 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    end_slot("coinc end");
`ifdef LOADER_CHECKSUM_EN
    chk("coinc checksum", 32'(checksum), 32'h0099);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
